// File: rtl/infix_to_postfix.sv
// ============================================================================
//  Module   : infix_to_postfix
//  Purpose  : Shunting-yard converter. It takes an infix token stream and
//             emits the postfix token stream on a number/sign strobe port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module infix_to_postfix #(
  parameter int DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] IN_TOKEN,
  input  logic       IN_IS_NUM,
  input  logic       IN_END,
  input  logic       IN_STB,
  output logic       BUSY,
  output logic [7:0] OUT_NUMBER,
  output logic       NUMBER_STB,
  output logic [7:0] OUT_SIGN,
  output logic       SIGN_STB,
  output logic       DONE,
  output logic       ERR
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;

  localparam logic [7:0] c_plus   = 8'h2B;
  localparam logic [7:0] c_minus  = 8'h2D;
  localparam logic [7:0] c_mul    = 8'h2A;
  localparam logic [7:0] c_div    = 8'h2F;
  localparam logic [7:0] c_lparen = 8'h28;
  localparam logic [7:0] c_rparen = 8'h29;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POP_OPS   = 3'd1,
    S_POP_PAREN = 3'd2,
    S_FLUSH     = 3'd3,
    S_FIN       = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  state_t           r_state;
  logic [7:0]       r_stack [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [7:0]       r_pend;

  logic             w_accept;
  logic             w_empty;
  logic             w_full;
  logic             w_is_op;
  logic [IDX_W-1:0] w_push_idx;
  logic [IDX_W-1:0] w_top_idx;
  logic [7:0]       w_top;

  // "(" sits at precedence 0 so it fences off everything beneath it.
  function automatic logic [1:0] prec(input logic [7:0] c);
    if (c == c_mul || c == c_div)        return 2'd2;
    else if (c == c_plus || c == c_minus) return 2'd1;
    else                                  return 2'd0;
  endfunction

  assign w_accept   = IN_STB && !BUSY && (r_state == S_IDLE);
  assign w_empty    = (r_ptr == '0);
  assign w_full     = (r_ptr == PTR_W'(DEPTH));
  assign w_is_op    = (IN_TOKEN == c_plus) || (IN_TOKEN == c_minus) ||
                      (IN_TOKEN == c_mul)  || (IN_TOKEN == c_div);
  assign w_push_idx = r_ptr[IDX_W-1:0];
  assign w_top_idx  = r_ptr[IDX_W-1:0] - IDX_W'(1);
  assign w_top      = r_stack[w_top_idx];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_pend     <= '0;
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
      BUSY       <= 1'b0;
      OUT_NUMBER <= '0;
      NUMBER_STB <= 1'b0;
      OUT_SIGN   <= '0;
      SIGN_STB   <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      NUMBER_STB <= 1'b0;
      SIGN_STB   <= 1'b0;
      DONE       <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (IN_IS_NUM && IN_END) begin
              r_state <= S_ERROR;
              BUSY    <= 1'b1;
              ERR     <= 1'b1;
            end else if (IN_END) begin
              r_state <= S_FLUSH;
              BUSY    <= 1'b1;
            end else if (IN_IS_NUM) begin
              OUT_NUMBER <= IN_TOKEN;
              NUMBER_STB <= 1'b1;
            end else if (IN_TOKEN == c_lparen) begin
              if (w_full) begin
                r_state <= S_ERROR;
                BUSY    <= 1'b1;
                ERR     <= 1'b1;
              end else begin
                r_stack[w_push_idx] <= IN_TOKEN;
                r_ptr               <= r_ptr + PTR_W'(1);
              end
            end else if (w_is_op) begin
              r_pend  <= IN_TOKEN;
              r_state <= S_POP_OPS;
              BUSY    <= 1'b1;
            end else if (IN_TOKEN == c_rparen) begin
              r_state <= S_POP_PAREN;
              BUSY    <= 1'b1;
            end else begin
              r_state <= S_ERROR;
              BUSY    <= 1'b1;
              ERR     <= 1'b1;
            end
          end
        end

        // >= gives left associativity: equal precedence pops first.
        S_POP_OPS: begin
          if (!w_empty && (prec(w_top) >= prec(r_pend))) begin
            OUT_SIGN <= w_top;
            SIGN_STB <= 1'b1;
            r_ptr    <= r_ptr - PTR_W'(1);
          end else if (w_full) begin
            r_state <= S_ERROR;
            ERR     <= 1'b1;
          end else begin
            r_stack[w_push_idx] <= r_pend;
            r_ptr               <= r_ptr + PTR_W'(1);
            r_state             <= S_IDLE;
            BUSY                <= 1'b0;
          end
        end

        S_POP_PAREN: begin
          if (w_empty) begin
            r_state <= S_ERROR;
            ERR     <= 1'b1;
          end else if (w_top == c_lparen) begin
            r_ptr   <= r_ptr - PTR_W'(1);
            r_state <= S_IDLE;
            BUSY    <= 1'b0;
          end else begin
            OUT_SIGN <= w_top;
            SIGN_STB <= 1'b1;
            r_ptr    <= r_ptr - PTR_W'(1);
          end
        end

        S_FLUSH: begin
          if (w_empty) begin
            r_state <= S_FIN;
            DONE    <= 1'b1;
          end else if (w_top == c_lparen) begin
            r_state <= S_ERROR;
            ERR     <= 1'b1;
          end else begin
            OUT_SIGN <= w_top;
            SIGN_STB <= 1'b1;
            r_ptr    <= r_ptr - PTR_W'(1);
          end
        end

        S_FIN: begin
          r_state <= S_IDLE;
          BUSY    <= 1'b0;
        end

        S_ERROR: begin
          BUSY <= 1'b1;
          ERR  <= 1'b1;
        end

        default: begin
          r_state <= S_ERROR;
          BUSY    <= 1'b1;
          ERR     <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_infix_to_postfix.sv
// ============================================================================
//  Module   : tb_infix_to_postfix
//  Purpose  : Scoreboard bench for infix_to_postfix.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_infix_to_postfix;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] IN_TOKEN = '0;
  logic       IN_IS_NUM = 1'b0;
  logic       IN_END = 1'b0;
  logic       IN_STB = 1'b0;
  logic       BUSY;
  logic [7:0] OUT_NUMBER;
  logic       NUMBER_STB;
  logic [7:0] OUT_SIGN;
  logic       SIGN_STB;
  logic       DONE;
  logic       ERR;

  int n_vec  = 0;
  int n_miss = 0;

  // Token code: [9:8] kind (1 number, 2 sign, 3 done), [7:0] value.
  logic [9:0] q_exp [$];

  always #5 CLK = ~CLK;

  infix_to_postfix #(.DEPTH(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_TOKEN   (IN_TOKEN),
    .IN_IS_NUM  (IN_IS_NUM),
    .IN_END     (IN_END),
    .IN_STB     (IN_STB),
    .BUSY       (BUSY),
    .OUT_NUMBER (OUT_NUMBER),
    .NUMBER_STB (NUMBER_STB),
    .OUT_SIGN   (OUT_SIGN),
    .SIGN_STB   (SIGN_STB),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic observe(input logic [9:0] t);
    logic [9:0] e;
    if (q_exp.size() == 0) begin
      check("extra_token", {22'd0, t}, 32'd0);
    end else begin
      e = q_exp.pop_front();
      check("token", {22'd0, t}, {22'd0, e});
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (NUMBER_STB && SIGN_STB) check("both_strobes", 32'd1, 32'd0);
      if (NUMBER_STB) observe({2'd1, OUT_NUMBER});
      if (SIGN_STB)   observe({2'd2, OUT_SIGN});
      if (DONE)       observe({2'd3, 8'd0});
    end
  end

  // Expected postfix as text: digit = number, operator = sign, D = done.
  task automatic expect_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] >= "0" && s[i] <= "9") q_exp.push_back({2'd1, s[i] - 8'h30});
      else if (s[i] == "D")           q_exp.push_back({2'd3, 8'd0});
      else                            q_exp.push_back({2'd2, s[i]});
    end
  endtask

  task automatic send(input logic [7:0] tok, input logic is_num, input logic is_end);
    int cnt;
    @(negedge CLK);
    IN_TOKEN  = tok;
    IN_IS_NUM = is_num;
    IN_END    = is_end;
    IN_STB    = 1'b1;
    cnt = 0;
    while (BUSY && cnt < 100) begin
      @(negedge CLK);
      cnt++;
    end
    if (cnt >= 100) check("busy_timeout", 32'd1, 32'd0);
    @(posedge CLK);
    #1;
    IN_STB = 1'b0;
    IN_END = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] >= "0" && s[i] <= "9") send(s[i] - 8'h30, 1'b1, 1'b0);
      else                            send(s[i], 1'b0, 1'b0);
    end
  endtask

  task automatic send_end();
    send(8'h00, 1'b0, 1'b1);
  endtask

  task automatic wait_drain(input string tag);
    int cnt;
    cnt = 0;
    while (q_exp.size() != 0 && cnt < 300) begin
      @(negedge CLK);
      cnt++;
    end
    repeat (4) @(negedge CLK);
    check(tag, q_exp.size(), 32'd0);
  endtask

  // Busy cycles seen right after an operator has been accepted.
  task automatic busy_len(output int n);
    n = 0;
    while (BUSY && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    q_exp.delete();
  endtask

  initial begin
    int lat;
    #12;
    check("rst_busy", BUSY, 0);
    check("rst_err", ERR, 0);
    check("rst_strobes", {NUMBER_STB, SIGN_STB, DONE}, 0);
    check("rst_data", {OUT_NUMBER, OUT_SIGN}, 0);
    @(negedge CLK);
    RST = 1'b0;

    expect_str("342*+D");
    send_str("3+4");
    send("*", 1'b0, 1'b0);
    busy_len(lat);
    check("mul_latency", lat, 1);
    send_str("2");
    send_end();
    wait_drain("expr_3+4*2");
    check("err_3+4*2", ERR, 0);
    check("idle_busy", BUSY, 0);

    expect_str("12+3*D");
    send_str("(1+2)*3");
    send_end();
    wait_drain("expr_paren");
    check("err_paren", ERR, 0);

    expect_str("83-2-D");
    send_str("8-3");
    send("-", 1'b0, 1'b0);
    busy_len(lat);
    check("minus_latency", lat, 2);
    send_str("2");
    send_end();
    wait_drain("expr_leftassoc_sub");

    expect_str("84/2*D");
    send_str("8/4*2");
    send_end();
    wait_drain("expr_leftassoc_div");

    expect_str("");
    for (int i = 0; i < 17; i++) send("(", 1'b0, 1'b0);
    repeat (5) @(negedge CLK);
    check("ovf_err", ERR, 1);
    check("ovf_busy", BUSY, 1);
    wait_drain("ovf_no_strobes");
    do_reset();
    check("clear_err", ERR, 0);

    expect_str("12+");
    send_str("1+2)");
    wait_drain("unmatched_rparen");
    check("rparen_err", ERR, 1);
    do_reset();

    expect_str("1");
    send_str("(1");
    send_end();
    wait_drain("unmatched_lparen");
    check("lparen_err", ERR, 1);
    check("lparen_busy", BUSY, 1);
    do_reset();

    expect_str("123");
    send_str("1+2*3");
    send_end();
    #3;
    RST = 1'b1;
    #1;
    check("async_busy", BUSY, 0);
    check("async_outs", {NUMBER_STB, SIGN_STB, DONE, ERR}, 0);
    check("async_data", {OUT_NUMBER, OUT_SIGN}, 0);
    @(negedge CLK);
    RST = 1'b0;
    wait_drain("after_abort");
    expect_str("5D");
    send_str("5");
    send_end();
    wait_drain("expr_5");
    check("err_5", ERR, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
